// File: rtl/serial_adder_ctrl_if.sv
// Handshake/result bundle for serial_adder_ctrl.
// With SERIAL_ADDER_SUB_EN defined the bundle also carries the sub request.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice sequenced LSB-first over WIDTH bits.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_adder_ctrl_if.slave bus_io
);
    localparam int unsigned CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    // Encoding chosen so busy and done come straight off state flops.
    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StRun  = 2'b01;
    localparam logic [1:0] StDone = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] load_b;
    logic             load_carry;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b is a + ~b + 1; cin is ignored when subtracting.
    assign load_b     = bus_io.sub ? ~bus_io.b : bus_io.b;
    assign load_carry = bus_io.sub ? 1'b1 : bus_io.cin;
`else
    assign load_b     = bus_io.b;
    assign load_carry = bus_io.cin;
`endif

    assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_bit = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] | b_q[0]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    a_d     = bus_io.a;
                    b_d     = load_b;
                    carry_d = load_carry;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = c_bit;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // carry_q is the carry into the MSB on this final bit.
                    cout_d  = c_bit;
                    ovf_d   = carry_q ^ c_bit;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus_io.busy = state_q[0];
    assign bus_io.done = state_q[1];
    assign bus_io.sum  = sum_q;
    assign bus_io.cout = cout_q;
    assign bus_io.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table plus multi-cycle corner sequences.
// Subtract vectors are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_adder_ctrl_if #(.WIDTH(8)) bus  ();
    serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_adder_ctrl #(.WIDTH(8)) dut   (.clk(clk), .rst(rst), .bus_io(bus));
    serial_adder_ctrl #(.WIDTH(2)) dut_w2 (.clk(clk), .rst(rst), .bus_io(bus2));

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
        bus.start = st;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = sub;
`else
        if (sub) $display("note: sub ignored without subtract build");
`endif
    endtask

    // Start at E0, expect busy through E8 and the done pulse visible after E8.
    task automatic run_op(input vec_t v);
        @(negedge clk);
        drive(1'b1, v.a, v.b, v.cin, v.sub);
        @(posedge clk); #1;
        chk({v.name, " busy@E0"}, {30'd0, bus.busy, bus.done}, 32'b10);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            chk({v.name, " busy mid"}, {30'd0, bus.busy, bus.done}, 32'b10);
        end
        @(posedge clk); #1;
        chk({v.name, " done"}, {30'd0, bus.busy, bus.done}, 32'b01);
        chk({v.name, " sum"},  {24'd0, bus.sum}, {24'd0, v.sum});
        chk({v.name, " cout"}, {31'd0, bus.cout}, {31'd0, v.cout});
        chk({v.name, " ovf"},  {31'd0, bus.ovf}, {31'd0, v.ovf});
        @(posedge clk); #1;
        chk({v.name, " idle"}, {30'd0, bus.busy, bus.done}, 32'b00);
    endtask

    initial begin
        int   done_cnt;
        vec_t v;
        total = 0;
        bad   = 0;

        vecs.push_back('{"add_3c_1a", 8'h3C, 8'h1A, 1'b0, 1'b0, 8'h56, 1'b0, 1'b0});
        vecs.push_back('{"add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{"add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{"add_cin",   8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{"add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{"add_aa_55", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{"sub_05_07",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{"sub_05_07_c", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{"sub_80_01",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{"sub_80_01_c", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus2.start = 1'b0;
        bus2.a     = 2'b00;
        bus2.b     = 2'b00;
        bus2.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus2.sub   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {21'd0, bus.busy, bus.done, bus.cout, bus.ovf, bus.sum}, 32'd0);

        // Reset wins over start at the same edge.
        @(negedge clk);
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("rst over start", {30'd0, bus.busy, bus.done}, 32'b00);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Start held high with operands churning: only E0/E10 captures matter.
        for (int e = 0; e <= 18; e++) begin
            @(negedge clk);
            if (e == 0)       drive(1'b1, 8'h3C, 8'h1A, 1'b0, 1'b0);
            else if (e == 10) drive(1'b1, 8'h10, 8'h20, 1'b1, 1'b0);
            else drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            @(posedge clk); #1;
            if (e == 0)  chk("hold E0 busy", {30'd0, bus.busy, bus.done}, 32'b10);
            if (e == 8) begin
                chk("hold E8 done", {30'd0, bus.busy, bus.done}, 32'b01);
                chk("hold E8 sum", {24'd0, bus.sum}, 32'h56);
            end
            if (e == 9) begin
                chk("hold E9 ignored", {30'd0, bus.busy, bus.done}, 32'b00);
                chk("hold E9 sum stable", {24'd0, bus.sum}, 32'h56);
            end
            if (e == 10) chk("hold E10 accept", {30'd0, bus.busy, bus.done}, 32'b10);
            if (e == 17) chk("hold E17 busy", {30'd0, bus.busy, bus.done}, 32'b10);
            if (e == 18) begin
                chk("hold E18 done", {30'd0, bus.busy, bus.done}, 32'b01);
                chk("hold E18 sum", {24'd0, bus.sum}, 32'h31);
            end
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        // Leave nonzero sum/ovf, then abort an operation at its 4th RUN edge.
        v = '{"pre_rst", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        run_op(v);
        @(negedge clk);
        drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun reset", {21'd0, bus.busy, bus.done, bus.cout, bus.ovf, bus.sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        chk("no done after abort", done_cnt, 32'd0);
        v = '{"after_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
        run_op(v);

        // WIDTH=2 instance: done visible after E2, sampled at the third edge.
        @(negedge clk);
        bus2.start = 1'b1;
        bus2.a     = 2'b11;
        bus2.b     = 2'b01;
        bus2.cin   = 1'b0;
        @(posedge clk); #1;
        chk("w2 busy@E0", {30'd0, bus2.busy, bus2.done}, 32'b10);
        @(negedge clk);
        bus2.start = 1'b0;
        @(posedge clk); #1;
        chk("w2 busy@E1", {30'd0, bus2.busy, bus2.done}, 32'b10);
        @(posedge clk); #1;
        chk("w2 done@E2", {30'd0, bus2.busy, bus2.done}, 32'b01);
        chk("w2 result", {28'd0, bus2.cout, bus2.ovf, bus2.sum}, {28'd0, 1'b1, 1'b0, 2'b00});
        @(posedge clk); #1;
        chk("w2 idle", {30'd0, bus2.busy, bus2.done}, 32'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
